star_box_drawer: RTL
====================

// Module: star_box_drawer
// PURPOSE
// - Downstream of the star scanner FSM: on goDraw, draws a rectangle outline around a star's bounding box on the
//   160x120 VGA frame, one pixel per clock. Output drives vga_adapter x/y/colour/plot. Returns a one-cycle doneDraw.
// - Bounding box comes from the star-map stage. Box is padded by MARGIN, clamped to screen, then drawn.
// PARAMETERS
// - X_W     8       x coordinate width
// - Y_W     7       y coordinate width
// - X_LAST  159     last screen column
// - Y_LAST  119     last screen row
// - MARGIN  1       pixels of padding added on every side of the star box (0..7)
// - COLOUR  3'b100  3-bit RGB drawing colour (1 bit per channel)
// PORTS
// - clk      in   1    system clock (CLOCK_50 domain)
// - reset    in   1    asynchronous, active-high reset
// - goDraw   in   1    level request from scanner FSM; held high until doneDraw is seen
// - xMinIn   in   X_W  star box left column
// - yMinIn   in   Y_W  star box top row
// - xMaxIn   in   X_W  star box right column
// - yMaxIn   in   Y_W  star box bottom row
// - x        out  X_W  pixel column to plot
// - y        out  Y_W  pixel row to plot
// - colour   out  3    pixel colour; equals COLOUR whenever plotEn=1, else 0
// - plotEn   out  1    write strobe to vga_adapter; x, y and colour are valid in the same cycle
// - doneDraw out  1    one-cycle pulse after the last pixel
// - busy     out  1    high in LOAD, DRAW and DONE
// BEHAVIOUR
// - Reset (async) forces state IDLE. Outputs x, y, colour, plotEn, doneDraw and busy are all 0.
// - States: IDLE -> LOAD -> DRAW -> DONE -> WAIT_LOW -> IDLE.
// - IDLE: when goDraw=1, go to LOAD. Bound inputs are sampled only in this cycle.
// - LOAD (1 cycle), on the registered inputs:
//   - If xMin>xMax, swap them. If yMin>yMax, swap them.
//   - x0 = max(xMin-MARGIN, 0) and x1 = min(xMax+MARGIN, X_LAST); y0/y1 are computed the same way.
//   - Use 1 extra bit for all padding arithmetic so there is no wrap-around.
// - DRAW: one pixel per cycle with plotEn=1. The first pixel appears in the cycle after LOAD. Each pixel is plotted exactly once.
//   - Top edge: y0, with x from x0 up to x1.
//   - Bottom edge: y1, with x from x0 up to x1. Skip it if y1==y0.
//   - Sides: for y from y0+1 up to y1-1, plot (x0,y) and then (x1,y). Skip (x1,y) if x1==x0.
//   - Total pixels = W + (H>1 ? W : 0) + (H-2 clipped at 0)*(W>1 ? 2 : 1), where W=x1-x0+1 and H=y1-y0+1.
// - DONE (1 cycle): doneDraw=1 and plotEn=0.
// - WAIT_LOW: stay until goDraw=0, then go to IDLE. This stops a held goDraw from retriggering the draw.
// - goDraw falling during LOAD/DRAW: abort to IDLE on the next edge. No doneDraw, no further plots.
// - goDraw high and the last pixel in the same cycle: normal completion into DONE.
// - Reset in any state: immediate return to IDLE and all outputs 0. The partially drawn box stays in frame memory.
// CONFIGURATION
// - STAR_BOX_FILL_EN defined: DRAW does a row-major solid fill. It covers y0..y1, and x0..x1 within each row, for W*H pixels.
//   The outline sequencing logic is not compiled.
// - STAR_BOX_FILL_EN undefined: outline as specified above. All handshake and timing rules are the same in both builds.
// STRUCTURE
// - Shared header star_defs.vh holds SCREEN_W=160, SCREEN_H=120, X_W, Y_W, COLOUR_W=3 and the colour constants.
//   The scanner, star map and this block all use it. State encodings stay local.
// - Sub-module box_bounds_clamp: combinational swap + pad + clamp that produces x0/x1/y0/y1.
// - The top level holds the FSM, the x/y walk counters and the edge-phase register.
// TESTING
// - Bounds (10,20)-(12,22), MARGIN=1:
//   - Box is (9,19)-(13,23).
//   - 16 plots in order: top row y=19 x 9..13; bottom row y=23 x 9..13; then (9,20),(13,20) .. (9,22),(13,22).
//   - Then one doneDraw pulse.
// - Bounds (0,0)-(0,0), MARGIN=1: clamp gives (0,0)-(1,1); 4 plots (0,0),(1,0),(0,1),(1,1); no wrap to x=255.
// - Bounds (159,119)-(159,119), MARGIN=2: box (157,117)-(159,119); 8 plots; no coordinate exceeds 159 or 119.
// - Swapped inputs (12,22)-(10,20), MARGIN=0: same 8 plots as the (10,20)-(12,22) box; MARGIN=0 single pixel (5,5): exactly 1 plot.
// - Handshake:
//   - goDraw held 5 cycles after doneDraw: no second draw occurs.
//   - goDraw dropped at the 3rd plot: plotEn=0 from the next cycle and doneDraw never pulses.
//   - reset asserted mid-draw: all outputs 0 asynchronously.
// - STAR_BOX_FILL_EN build with (10,20)-(12,22), MARGIN=1: 25 plots in row-major order from (9,19) to (13,23), then doneDraw.

Source files
------------

// File: rtl/star_box_drawer_pkg.sv
// Shared screen geometry, colour constants and edge-walk phase encoding for the
// star pipeline (scanner, star map and box drawer).
package star_box_drawer_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int STAR_X_W = 8;
    localparam int STAR_Y_W = 7;
    localparam int COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'b000;
    localparam logic [COLOUR_W-1:0] COLOUR_RED   = 3'b100;
    localparam logic [COLOUR_W-1:0] COLOUR_GREEN = 3'b010;
    localparam logic [COLOUR_W-1:0] COLOUR_BLUE  = 3'b001;
    localparam logic [COLOUR_W-1:0] COLOUR_WHITE = 3'b111;

    // Which part of the outline the walker is on.
    typedef enum logic [1:0] {
        PH_TOP    = 2'd0,
        PH_BOTTOM = 2'd1,
        PH_SIDES  = 2'd2
    } edge_phase_e;

endpackage

// File: rtl/star_box_drawer_bounds_clamp.sv
// box_bounds_clamp: orders the raw star bounds, pads them by MARGIN and clamps
// the result to the visible screen. Purely combinational.
module box_bounds_clamp #(
    parameter int X_W    = 8,
    parameter int Y_W    = 7,
    parameter int X_LAST = 159,
    parameter int Y_LAST = 119,
    parameter int MARGIN = 1
) (
    input  logic [X_W-1:0] xMin_i,
    input  logic [X_W-1:0] xMax_i,
    input  logic [Y_W-1:0] yMin_i,
    input  logic [Y_W-1:0] yMax_i,
    output logic [X_W-1:0] x0_o,
    output logic [X_W-1:0] x1_o,
    output logic [Y_W-1:0] y0_o,
    output logic [Y_W-1:0] y1_o
);

    localparam logic [X_W:0] MARGIN_X = (X_W+1)'(MARGIN);
    localparam logic [Y_W:0] MARGIN_Y = (Y_W+1)'(MARGIN);
    localparam logic [X_W:0] LAST_X   = (X_W+1)'(X_LAST);
    localparam logic [Y_W:0] LAST_Y   = (Y_W+1)'(Y_LAST);

    logic [X_W:0] xLoW, xHiW;
    logic [Y_W:0] yLoW, yHiW;

    // The extra top bit keeps min-MARGIN from wrapping below 0 and max+MARGIN from wrapping past the width.
    always_comb begin
        if (xMin_i > xMax_i) begin
            xLoW = {1'b0, xMax_i};
            xHiW = {1'b0, xMin_i} + MARGIN_X;
        end else begin
            xLoW = {1'b0, xMin_i};
            xHiW = {1'b0, xMax_i} + MARGIN_X;
        end
        if (yMin_i > yMax_i) begin
            yLoW = {1'b0, yMax_i};
            yHiW = {1'b0, yMin_i} + MARGIN_Y;
        end else begin
            yLoW = {1'b0, yMin_i};
            yHiW = {1'b0, yMax_i} + MARGIN_Y;
        end

        x0_o = (xLoW >= MARGIN_X) ? X_W'(xLoW - MARGIN_X) : '0;
        y0_o = (yLoW >= MARGIN_Y) ? Y_W'(yLoW - MARGIN_Y) : '0;
        x1_o = (xHiW > LAST_X) ? X_W'(LAST_X) : X_W'(xHiW);
        y1_o = (yHiW > LAST_Y) ? Y_W'(LAST_Y) : Y_W'(yHiW);
    end

endmodule

// File: rtl/star_box_drawer.sv
// Draws a padded, clamped rectangle around a star's bounding box, one pixel per clock.
// Define STAR_BOX_FILL_EN to draw a solid row-major fill instead of the outline.
module star_box_drawer
    import star_box_drawer_pkg::*;
#(
    parameter int                   X_W    = STAR_X_W,
    parameter int                   Y_W    = STAR_Y_W,
    parameter int                   X_LAST = SCREEN_W - 1,
    parameter int                   Y_LAST = SCREEN_H - 1,
    parameter int                   MARGIN = 1,
    parameter logic [COLOUR_W-1:0]  COLOUR = COLOUR_RED
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                goDraw,
    input  logic [X_W-1:0]      xMinIn,
    input  logic [Y_W-1:0]      yMinIn,
    input  logic [X_W-1:0]      xMaxIn,
    input  logic [Y_W-1:0]      yMaxIn,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plotEn,
    output logic                doneDraw,
    output logic                busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_DRAW     = 3'd2,
        S_DONE     = 3'd3,
        S_WAIT_LOW = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic [X_W-1:0] xMin_q, xMax_q;
    logic [Y_W-1:0] yMin_q, yMax_q;
    logic [X_W-1:0] x0_c, x1_c, x0_q, x1_q;
    logic [Y_W-1:0] y0_c, y1_c, y0_q, y1_q;
    logic [X_W-1:0] xCnt_q, xCnt_d;
    logic [Y_W-1:0] yCnt_q, yCnt_d;
    logic           lastPix;
`ifndef STAR_BOX_FILL_EN
    edge_phase_e    phase_q, phase_d;
    logic           right_q, right_d;
`endif

    box_bounds_clamp #(
        .X_W    (X_W),
        .Y_W    (Y_W),
        .X_LAST (X_LAST),
        .Y_LAST (Y_LAST),
        .MARGIN (MARGIN)
    ) uClamp (
        .xMin_i (xMin_q),
        .xMax_i (xMax_q),
        .yMin_i (yMin_q),
        .yMax_i (yMax_q),
        .x0_o   (x0_c),
        .x1_o   (x1_c),
        .y0_o   (y0_c),
        .y1_o   (y1_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A dropped goDraw wins over everything in LOAD/DRAW, including the last pixel.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (goDraw) state_d = S_LOAD;
            S_LOAD:     state_d = goDraw ? S_DRAW : S_IDLE;
            S_DRAW: begin
                if (!goDraw)      state_d = S_IDLE;
                else if (lastPix) state_d = S_DONE;
            end
            S_DONE:     state_d = S_WAIT_LOW;
            S_WAIT_LOW: if (!goDraw) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        plotEn   = (state_q == S_DRAW);
        doneDraw = (state_q == S_DONE);
        busy     = (state_q == S_LOAD) || (state_q == S_DRAW) || (state_q == S_DONE);
        x        = plotEn ? xCnt_q : '0;
        y        = plotEn ? yCnt_q : '0;
        colour   = plotEn ? COLOUR : '0;
    end

    always_comb begin
        xCnt_d  = xCnt_q;
        yCnt_d  = yCnt_q;
        lastPix = 1'b0;
`ifndef STAR_BOX_FILL_EN
        phase_d = phase_q;
        right_d = right_q;
`endif
        if (state_q == S_LOAD) begin
            xCnt_d = x0_c;
            yCnt_d = y0_c;
`ifndef STAR_BOX_FILL_EN
            phase_d = PH_TOP;
            right_d = 1'b0;
`endif
        end else if (state_q == S_DRAW) begin
`ifdef STAR_BOX_FILL_EN
            if (xCnt_q != x1_q) begin
                xCnt_d = xCnt_q + X_W'(1);
            end else if (yCnt_q == y1_q) begin
                lastPix = 1'b1;
            end else begin
                xCnt_d = x0_q;
                yCnt_d = yCnt_q + Y_W'(1);
            end
`else
            // Top row, then bottom row, then left/right pairs for the interior rows.
            unique case (phase_q)
                PH_TOP: begin
                    if (xCnt_q != x1_q) begin
                        xCnt_d = xCnt_q + X_W'(1);
                    end else if (y1_q == y0_q) begin
                        lastPix = 1'b1;
                    end else begin
                        phase_d = PH_BOTTOM;
                        xCnt_d  = x0_q;
                        yCnt_d  = y1_q;
                    end
                end
                PH_BOTTOM: begin
                    if (xCnt_q != x1_q) begin
                        xCnt_d = xCnt_q + X_W'(1);
                    end else if ((y1_q - y0_q) < Y_W'(2)) begin
                        lastPix = 1'b1;
                    end else begin
                        phase_d = PH_SIDES;
                        xCnt_d  = x0_q;
                        yCnt_d  = y0_q + Y_W'(1);
                        right_d = 1'b0;
                    end
                end
                PH_SIDES: begin
                    if (!right_q && (x1_q != x0_q)) begin
                        xCnt_d  = x1_q;
                        right_d = 1'b1;
                    end else if (yCnt_q == (y1_q - Y_W'(1))) begin
                        lastPix = 1'b1;
                    end else begin
                        xCnt_d  = x0_q;
                        yCnt_d  = yCnt_q + Y_W'(1);
                        right_d = 1'b0;
                    end
                end
                default: phase_d = PH_TOP;
            endcase
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xMin_q  <= '0;
            xMax_q  <= '0;
            yMin_q  <= '0;
            yMax_q  <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            xCnt_q  <= '0;
            yCnt_q  <= '0;
`ifndef STAR_BOX_FILL_EN
            phase_q <= PH_TOP;
            right_q <= 1'b0;
`endif
        end else begin
            if ((state_q == S_IDLE) && goDraw) begin
                xMin_q <= xMinIn;
                xMax_q <= xMaxIn;
                yMin_q <= yMinIn;
                yMax_q <= yMaxIn;
            end
            if (state_q == S_LOAD) begin
                x0_q <= x0_c;
                x1_q <= x1_c;
                y0_q <= y0_c;
                y1_q <= y1_c;
            end
            xCnt_q  <= xCnt_d;
            yCnt_q  <= yCnt_d;
`ifndef STAR_BOX_FILL_EN
            phase_q <= phase_d;
            right_q <= right_d;
`endif
        end
    end

endmodule
